// File: rtl/traffic_pkg.sv
// Shared types for the three-route traffic light controller and its safety monitor.
// Lamp encoding, route indices, fault causes and monitor states live here.
package traffic_pkg;

  typedef enum logic [1:0] {
    RED     = 2'b00,
    YELLOW  = 2'b01,
    GREEN   = 2'b10,
    INVALID = 2'b11
  } lamp_t;

  localparam int NUM_ROUTES = 3;
  localparam int BLUE       = 2;
  localparam int BLACK      = 1;
  localparam int YELLOW_RT  = 0;

  // Lower code means higher priority when several checks fire together.
  typedef enum logic [2:0] {
    FC_NONE      = 3'd0,
    FC_INVALID   = 3'd1,
    FC_CONFLICT  = 3'd2,
    FC_ILLEGAL   = 3'd3,
    FC_SHORT_YEL = 3'd4,
    FC_WATCHDOG  = 3'd5
  } fault_code_t;

  typedef enum logic [1:0] {
    ARM   = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } mon_state_t;

  function automatic lamp_t route_lamp(input logic [5:0] vec, input int route);
    return lamp_t'(vec[2*route +: 2]);
  endfunction

endpackage

// File: rtl/traffic_route_check.sv
// Per-route combinational checks: lamp code validity, non-red status and
// legality of the step from the previous lamp to the current one.
module traffic_route_check
  import traffic_pkg::*;
(
  input  lamp_t prev,
  input  lamp_t cur,
  output logic  invalid,
  output logic  nonred,
  output logic  illegal_trans,
  output logic  yel_to_red
);

  logic legal_step;

  assign invalid    = (cur == INVALID);
  assign nonred     = (cur != RED);
  assign yel_to_red = (prev == YELLOW) && (cur == RED);

  // Only the red -> green -> yellow -> red cycle, or holding, is allowed.
  assign legal_step = (cur == prev)
                    || ((prev == RED)   && (cur == GREEN))
                    || ((prev == GREEN) && (cur == YELLOW))
                    || yel_to_red;

  assign illegal_trans = !legal_step;

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Safety stage between the traffic light controller and the lamp drivers:
// forwards r_in one cycle late, latches a fault and forces all-red on any violation.
module traffic_conflict_monitor
  import traffic_pkg::*;
#(
  parameter int MIN_YELLOW = 2,
  parameter int MAX_HOLD   = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] r_in,
  input  logic       clear,
  output logic [5:0] lamp_out,
  output logic       fault,
  output logic [2:0] fault_code
);

  localparam int YW = $clog2(MIN_YELLOW + 1);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [YW-1:0] YEL_MIN  = YW'(MIN_YELLOW);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

  mon_state_t  state, state_nxt;
  fault_code_t code_q, code_nxt, cause;

  logic [5:0]    prev, prev_nxt;
  logic [5:0]    lamp_nxt;
  logic          fault_nxt;
  logic [YW-1:0] yel_cnt, yel_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt, hold_inc;

  logic [NUM_ROUTES-1:0] invalid_v, nonred_v, illegal_v, y2r_v, yellow_v;
  logic conflict, same, short_yel, watchdog, clear_ok;

  traffic_route_check u_blue (
    .prev          (route_lamp(prev, BLUE)),
    .cur           (route_lamp(r_in, BLUE)),
    .invalid       (invalid_v[BLUE]),
    .nonred        (nonred_v[BLUE]),
    .illegal_trans (illegal_v[BLUE]),
    .yel_to_red    (y2r_v[BLUE])
  );

  traffic_route_check u_black (
    .prev          (route_lamp(prev, BLACK)),
    .cur           (route_lamp(r_in, BLACK)),
    .invalid       (invalid_v[BLACK]),
    .nonred        (nonred_v[BLACK]),
    .illegal_trans (illegal_v[BLACK]),
    .yel_to_red    (y2r_v[BLACK])
  );

  traffic_route_check u_yellow (
    .prev          (route_lamp(prev, YELLOW_RT)),
    .cur           (route_lamp(r_in, YELLOW_RT)),
    .invalid       (invalid_v[YELLOW_RT]),
    .nonred        (nonred_v[YELLOW_RT]),
    .illegal_trans (illegal_v[YELLOW_RT]),
    .yel_to_red    (y2r_v[YELLOW_RT])
  );

  always_comb begin
    yellow_v = '0;
    for (int i = 0; i < NUM_ROUTES; i++) begin
      yellow_v[i] = (route_lamp(r_in, i) == YELLOW);
    end
  end

  assign conflict  = ($countones(nonred_v) > 1);
  assign same      = (r_in == prev);
  assign clear_ok  = clear && (r_in == 6'b000000);
  assign hold_inc  = (&hold_cnt) ? hold_cnt : hold_cnt + 1'b1;
  // yel_cnt still holds the length of the yellow phase on the yellow->red cycle.
  assign short_yel = (|y2r_v) && (yel_cnt < YEL_MIN);
  assign watchdog  = same && (hold_inc == HOLD_MAX);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    cause = FC_NONE;
    if (|invalid_v) begin
      cause = FC_INVALID;
    end else if (conflict) begin
      cause = FC_CONFLICT;
    end else if (state == RUN) begin
      if (|illegal_v) begin
        cause = FC_ILLEGAL;
      end else if (short_yel) begin
        cause = FC_SHORT_YEL;
      end else if (watchdog) begin
        cause = FC_WATCHDOG;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    lamp_nxt  = 6'b000000;
    fault_nxt = fault;
    code_nxt  = code_q;
    if (clear_ok) begin
      state_nxt = ARM;
      fault_nxt = 1'b0;
      code_nxt  = FC_NONE;
    end else begin
      unique case (state)
        ARM, RUN: begin
          if (cause != FC_NONE) begin
            state_nxt = FAULT;
            fault_nxt = 1'b1;
            code_nxt  = cause;
          end else begin
            state_nxt = RUN;
            lamp_nxt  = r_in;
            fault_nxt = 1'b0;
            code_nxt  = FC_NONE;
          end
        end
        FAULT: begin
          state_nxt = FAULT;
        end
        default: begin
          state_nxt = ARM;
          fault_nxt = 1'b0;
          code_nxt  = FC_NONE;
        end
      endcase
    end
  end

  always_comb begin
    yel_nxt  = '0;
    hold_nxt = '0;
    prev_nxt = prev;
    if (|yellow_v) begin
      yel_nxt = (&yel_cnt) ? yel_cnt : yel_cnt + 1'b1;
    end
    if ((state == RUN) && same) begin
      hold_nxt = hold_inc;
    end
    if (state != FAULT) begin
      prev_nxt = r_in;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (reset) begin
      state    <= ARM;
      prev     <= '0;
      lamp_out <= '0;
      fault    <= 1'b0;
      code_q   <= FC_NONE;
      yel_cnt  <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      prev     <= prev_nxt;
      lamp_out <= lamp_nxt;
      fault    <= fault_nxt;
      code_q   <= code_nxt;
      yel_cnt  <= yel_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  assign fault_code = code_q;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Self-checking bench for traffic_conflict_monitor: directed scenarios followed by
// randomized traffic, all compared against a rule-level reference model.
module tb_traffic_conflict_monitor;
  import traffic_pkg::*;

  localparam int MIN_YELLOW = 2;
  localparam int MAX_HOLD   = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic [5:0] r_in;
  logic [5:0] lamp_out;
  logic       fault;
  logic [2:0] fault_code;

  traffic_conflict_monitor #(
    .MIN_YELLOW (MIN_YELLOW),
    .MAX_HOLD   (MAX_HOLD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .r_in       (r_in),
    .clear      (clear),
    .lamp_out   (lamp_out),
    .fault      (fault),
    .fault_code (fault_code)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: tracks the rules directly on route colours and run lengths.
  logic       m_fault;
  int         m_code;
  logic [5:0] m_lamp;
  logic       m_first;
  logic [5:0] m_last;
  int         m_yel_run;
  int         m_same_run;
  // Successor of each colour in the legal cycle: red->green, yellow->red, green->yellow.
  int         next_colour [3] = '{2, 0, 1};

  function automatic int colour(input logic [5:0] v, input int route);
    return int'((v >> (2 * route)) & 6'd3);
  endfunction

  task automatic model_step(input logic [5:0] r, input logic c, input logic rs);
    int   preceding_yellow;
    int   nonred;
    int   code;
    int   col;
    int   was;
    logic has_yellow;
    logic has_invalid;
    logic bad_step;
    logic yel_red;
    if (rs) begin
      m_fault    = 1'b0;
      m_code     = 0;
      m_lamp     = 6'b000000;
      m_first    = 1'b1;
      m_last     = 6'b000000;
      m_yel_run  = 0;
      m_same_run = 0;
      return;
    end
    preceding_yellow = m_yel_run;
    nonred      = 0;
    has_yellow  = 1'b0;
    has_invalid = 1'b0;
    bad_step    = 1'b0;
    yel_red     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      col = colour(r, i);
      was = colour(m_last, i);
      if (col == 1) has_yellow = 1'b1;
      if (col != 0) nonred++;
      if (col == 3) has_invalid = 1'b1;
      if (was < 3 && !(col == was || col == next_colour[was])) bad_step = 1'b1;
      if (was == 1 && col == 0) yel_red = 1'b1;
    end
    m_yel_run = has_yellow ? m_yel_run + 1 : 0;
    if (m_fault) begin
      if (c && r == 6'b000000) begin
        m_fault = 1'b0;
        m_code  = 0;
        m_first = 1'b1;
      end
      m_lamp = 6'b000000;
      return;
    end
    m_same_run = (!m_first && r == m_last) ? m_same_run + 1 : 0;
    code = 0;
    if (has_invalid) code = 1;
    else if (nonred > 1) code = 2;
    else if (!m_first) begin
      if (bad_step) code = 3;
      else if (yel_red && preceding_yellow < MIN_YELLOW) code = 4;
      else if (m_same_run >= MAX_HOLD) code = 5;
    end
    if (code != 0) begin
      m_fault = 1'b1;
      m_code  = code;
      m_lamp  = 6'b000000;
    end else begin
      m_lamp  = r;
      m_first = 1'b0;
      m_last  = r;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic [5:0] r, input logic c, input logic rs, input string tag);
    r_in  = r;
    clear = c;
    reset = rs;
    @(posedge clk);
    model_step(r, c, rs);
    #1;
    check({tag, ".lamp_out"},   8'(lamp_out),   8'(m_lamp));
    check({tag, ".fault"},      8'(fault),      8'(m_fault));
    check({tag, ".fault_code"}, 8'(fault_code), 8'(m_code));
  endtask

  task automatic expect_out(input string tag, input logic [5:0] l, input logic f, input logic [2:0] c);
    check({tag, ".lamp_const"},  8'(lamp_out),   8'(l));
    check({tag, ".fault_const"}, 8'(fault),      8'(f));
    check({tag, ".code_const"},  8'(fault_code), 8'(c));
  endtask

  function automatic logic [5:0] advance(input logic [5:0] v);
    int         route;
    logic [5:0] res;
    route = int'($urandom_range(2));
    res   = v;
    for (int i = 0; i < 3; i++) begin
      if (colour(v, i) != 0) route = i;
    end
    res[2*route +: 2] = 2'(next_colour[colour(v, route)]);
    return res;
  endfunction

  initial begin
    logic [5:0] nr;
    logic       c;
    logic       rs;
    int         sel;

    r_in  = 6'b000000;
    clear = 1'b0;
    reset = 1'b1;

    apply(6'b000000, 1'b0, 1'b1, "reset0");
    apply(6'b000000, 1'b0, 1'b1, "reset1");
    expect_out("reset", 6'b000000, 1'b0, 3'd0);

    // Legal cycle on the blue route, then black goes green.
    for (int i = 0; i < 3; i++) begin
      apply(6'b100000, 1'b0, 1'b0, "legal_green");
      expect_out("legal_green", 6'b100000, 1'b0, 3'd0);
    end
    for (int i = 0; i < 2; i++) begin
      apply(6'b010000, 1'b0, 1'b0, "legal_yellow");
      expect_out("legal_yellow", 6'b010000, 1'b0, 3'd0);
    end
    apply(6'b000000, 1'b0, 1'b0, "legal_red");
    expect_out("legal_red", 6'b000000, 1'b0, 3'd0);
    apply(6'b001000, 1'b0, 1'b0, "legal_black");
    expect_out("legal_black", 6'b001000, 1'b0, 3'd0);

    // Conflict: two greens never reach the lamps.
    apply(6'b101000, 1'b0, 1'b0, "conflict");
    expect_out("conflict", 6'b000000, 1'b1, FC_CONFLICT);
    apply(6'b101000, 1'b0, 1'b0, "conflict_hold");
    expect_out("conflict_hold", 6'b000000, 1'b1, FC_CONFLICT);
    apply(6'b000000, 1'b1, 1'b0, "clear1");
    expect_out("clear1", 6'b000000, 1'b0, 3'd0);

    // Short yellow: one yellow cycle then red.
    apply(6'b100000, 1'b0, 1'b0, "sy_green");
    apply(6'b010000, 1'b0, 1'b0, "sy_yellow");
    apply(6'b000000, 1'b0, 1'b0, "short_yellow");
    expect_out("short_yellow", 6'b000000, 1'b1, FC_SHORT_YEL);
    apply(6'b000000, 1'b1, 1'b0, "clear2");

    // Green straight to red.
    apply(6'b100000, 1'b0, 1'b0, "il_green");
    apply(6'b000000, 1'b0, 1'b0, "illegal");
    expect_out("illegal", 6'b000000, 1'b1, FC_ILLEGAL);
    apply(6'b000000, 1'b1, 1'b0, "clear3");

    // Invalid code plus conflict in one vector: invalid wins.
    apply(6'b110000, 1'b0, 1'b0, "simul");
    expect_out("simul", 6'b000000, 1'b1, FC_INVALID);
    apply(6'b000000, 1'b1, 1'b0, "clear4");

    // Watchdog: nine identical samples starting in the arm cycle.
    for (int i = 0; i < 8; i++) begin
      apply(6'b000100, 1'b0, 1'b0, "wd_hold");
    end
    expect_out("wd_before", 6'b000100, 1'b0, 3'd0);
    apply(6'b000100, 1'b0, 1'b0, "watchdog");
    expect_out("watchdog", 6'b000000, 1'b1, FC_WATCHDOG);
    apply(6'b000100, 1'b1, 1'b0, "clear_nonred");
    expect_out("clear_nonred", 6'b000000, 1'b1, FC_WATCHDOG);
    apply(6'b000000, 1'b1, 1'b0, "clear5");
    expect_out("clear5", 6'b000000, 1'b0, 3'd0);

    // Reset while faulted outranks clear and the violating input.
    apply(6'b110000, 1'b0, 1'b0, "refault");
    expect_out("refault", 6'b000000, 1'b1, FC_INVALID);
    apply(6'b110000, 1'b1, 1'b1, "reset_in_fault");
    expect_out("reset_in_fault", 6'b000000, 1'b0, 3'd0);
    apply(6'b100000, 1'b0, 1'b0, "post_reset");
    expect_out("post_reset", 6'b100000, 1'b0, 3'd0);

    // Randomized traffic biased toward legal sequences.
    for (int n = 0; n < 3000; n++) begin
      rs  = ($urandom_range(199) == 0);
      c   = 1'b0;
      sel = int'($urandom_range(99));
      if (m_fault) begin
        c  = ($urandom_range(2) == 0);
        nr = (sel < 50) ? 6'b000000 : 6'($urandom);
      end else if (sel < 55) begin
        nr = m_last;
      end else if (sel < 93) begin
        nr = advance(m_last);
      end else begin
        nr = 6'($urandom);
      end
      apply(nr, c, rs, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/traffic_conflict_monitor.md
# traffic_conflict_monitor

Safety stage directly downstream of the three-route traffic light controller. It takes the controller's packed 6-bit lamp vector (blue, black, yellow routes), checks every cycle for invalid codes, conflicting non-red routes, illegal colour sequences, short yellows and a stuck controller, and forwards the vector to the lamp drivers one cycle later. On any violation it latches a fault, forces all routes red and holds them red until an explicit clear.

## Interface
- `MIN_YELLOW`, default 2: minimum consecutive yellow cycles before yellow->red is allowed.
- `MAX_HOLD`, default 64: watchdog limit on consecutive cycles of an unchanged `r_in`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `r_in` in 6: controller lamp vector; [5:4] blue, [3:2] black, [1:0] yellow route.
- `clear` in 1: fault acknowledge; level-sampled.
- `lamp_out` out 6: vector sent to the lamp drivers, same packing as `r_in`.
- `fault` out 1: latched fault flag.
- `fault_code` out 3: cause of the latched fault; 0 when `fault`=0.

## Operation
- Lamp encoding per route: 00 red, 01 yellow, 10 green, 11 invalid.
- States: ARM, RUN, FAULT.
- ARM: occupies the first cycle after reset or clear. Runs only the invalid and conflict checks. Captures `r_in` as the previous value, then goes to RUN if no violation.
- RUN: runs all checks on `r_in` against the registered previous value `prev`.
- Checks, in priority order (lowest code wins when several fire together):
  - 1 invalid: any route = 11.
  - 2 conflict: more than one route non-red.
  - 3 illegal transition: per route, only hold, red->green, green->yellow and yellow->red are legal. Red->yellow, green->red and yellow->green are illegal.
  - 4 short yellow: a route goes yellow->red while `yel_cnt` < `MIN_YELLOW`.
  - 5 watchdog: `hold_cnt` reaches `MAX_HOLD`.
- `yel_cnt`:
  - Increments, saturating, on every cycle in which some route of `r_in` is yellow.
  - Is 0 on every other cycle.
  - At a yellow->red cycle it therefore holds the number of preceding yellow cycles.
- `hold_cnt`:
  - Increments, saturating, when `r_in` == `prev`.
  - Clears to 0 on any change.
  - Counts in RUN only.
- Any violation: next state FAULT, `fault` set to 1, `fault_code` loaded with the cause, `lamp_out` set to 000000.
- FAULT:
  - `lamp_out` stays 000000 and `fault_code` is frozen.
  - Further violations are ignored.
  - `clear`=1 together with `r_in`=000000: next state ARM, `fault` and `fault_code` return to 0.
  - `clear`=1 with any other `r_in`: ignored.
- Outside FAULT: `lamp_out` <= `r_in`.

## Timing
- Reset values: `lamp_out`=000000, `fault`=0, `fault_code`=0, state ARM, `prev`=000000, `yel_cnt`=0, `hold_cnt`=0.
- Reset mid-operation, including in FAULT, gives the same values on the next edge.
- Pass-through latency is 1 cycle: `r_in` sampled at edge n appears on `lamp_out` after edge n.
- Fault latency is 1 cycle. A violating `r_in` never reaches `lamp_out`: the same edge that sets `fault` drives `lamp_out` to 000000.
- Clear latency is 1 cycle to ARM. Normal forwarding resumes from the ARM cycle.
- `reset` has priority over `clear`, and `clear` has priority over violation detection.
- Counter widths:
  - `yel_cnt`: $clog2(`MIN_YELLOW`+1) bits.
  - `hold_cnt`: $clog2(`MAX_HOLD`+1) bits.
  - Both saturate and never wrap.

## Structure
- Shared `traffic_pkg` holds:
  - `lamp_t` enum: RED, YELLOW, GREEN, INVALID.
  - Route index constants: BLUE=2, BLACK=1, YELLOW_RT=0.
  - `fault_code_t` enum, values 0..5.
  - `mon_state_t` enum: ARM, RUN, FAULT.
- The controller and its bench use the same package.
- Sub-module `traffic_route_check`: combinational, one instance per route. Inputs are the previous and current `lamp_t`. Outputs are `invalid`, `nonred`, `illegal_trans` and `yel_to_red`.

## Test plan
- Legal cycle: drive 100000 for 3 cycles, 010000 for 2, 000000 for 1, then 001000.
  - `lamp_out` follows 1 cycle late and `fault` stays 0 throughout.
- Conflict: `r_in`=101000.
  - Next edge: `fault`=1, `fault_code`=2, `lamp_out`=000000.
  - `lamp_out` never shows 101000.
- Short yellow (`MIN_YELLOW`=2): drive 100000, then 010000 for 1 cycle, then 000000.
  - `fault_code`=4.
- Illegal transition: drive 100000 then 000000 (green->red).
  - `fault_code`=3.
- Simultaneous events: drive 110000.
  - Only `fault_code`=1 is reported, because invalid outranks conflict.
- Watchdog and clear (`MAX_HOLD`=8): hold 000100 for 9 cycles.
  - `fault_code`=5.
  - `clear`=1 with `r_in`=000100: stays in FAULT.
  - `clear`=1 with `r_in`=000000: `fault`=0 next edge.
  - `reset` asserted in FAULT: all outputs 0 next edge.
